// File: rtl/lfsr_word_packer_pkg.sv
// Shared types and default parameters for the LFSR word packer.
package lfsr_word_packer_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_RUN_LIMIT = 32;

  typedef enum logic {
    FILL = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr_word_fifo.sv
// Two-entry first-in first-out word buffer. Slot 0 is always the head, so the
// output needs no read pointer; a pop shifts slot 1 down into slot 0.
module lfsr_word_fifo
  import lfsr_word_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_pop;
  logic             do_push;

  // Next-state for the slots and occupancy; a push into a full buffer only
  // lands if the head is leaving on the same edge.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          slot0_d = din_i;
        end else begin
          slot1_d = din_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = din_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Buffer storage and occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign dout_o  = empty_o ? '0 : slot0_q;

endmodule

// File: rtl/lfsr_word_packer.sv
// Packs the serial LFSR stream into words, buffers them for a valid/ready
// sink and runs a repetition-count health test on the raw bits.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | normal operation, completed words are pushed to the buffer
//   HALT  | stuck stream seen; no more pushes, buffer still drains;
//         | left only by reset
module lfsr_word_packer
  import lfsr_word_packer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RUN_LIMIT = DEF_RUN_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             stuck_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int RUN_W = $clog2(RUN_LIMIT + 1);

  state_e           state_q, state_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] word_c;
  logic             last_bit;
  logic             stuck_hit;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // The completed word is the stored bits plus the current one, first bit at MSB.
  assign word_c   = {shreg_q, bit_in};
  assign last_bit = (count_q == CNT_W'(WIDTH - 1));
  assign pop      = word_valid && word_ready;

  // Shift register and bit counter advance only on valid bits.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (bit_valid) begin
      shreg_d = word_c[WIDTH-2:0];
      count_d = last_bit ? '0 : count_q + 1'b1;
    end
  end

  // Repetition count; run_q==0 only before the first bit after reset.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    if (bit_valid) begin
      prev_d = bit_in;
      if (run_q == '0 || bit_in != prev_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_W'(RUN_LIMIT)) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign stuck_hit = bit_valid && (run_d == RUN_W'(RUN_LIMIT));

  // FSM next state and push decision; a word finishing on the same edge the
  // error latches is discarded without counting as an overflow.
  always_comb begin
    state_d    = state_q;
    push_req   = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      FILL: begin
        if (stuck_hit) begin
          state_d = HALT;
        end else if (bit_valid && last_bit) begin
          push_req = 1'b1;
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, packing and health-test registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      shreg_q    <= '0;
      count_q    <= '0;
      run_q      <= '0;
      prev_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  lfsr_word_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (word_c),
    .dout_o  (word_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;
  assign stuck_err  = (state_q == HALT);

endmodule
